// File: rtl/mux_scan_reg_pkg.sv
// Shared mode/state definitions for mux_scan_reg and its helpers.
// The optional parity output is controlled by MUX_SCAN_PARITY_EN in the top.
package mux_scan_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

endpackage : mux_scan_pkg

// File: rtl/mux_scan_reg_rr_next_sel.sv
// Round-robin search: first set bit of mask strictly after cur, wrapping to 0.
// With cur = NCH-1 this yields the lowest set bit; with a single set bit equal to cur it returns cur.
module rr_next_sel #(
   parameter int NCH = 8,
   localparam int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  mask,
   input  logic [SELW-1:0] cur,
   output logic [SELW-1:0] nxt,
   output logic            any
);

   int  chan;
   logic found;

   // Walk the channels in wrap-around order starting just past cur; the last probe is cur itself.
   always_comb begin
      nxt   = cur;
      found = 1'b0;
      chan  = 0;
      for (int i = 1; i <= NCH; i++) begin
         chan = (int'(cur) + i) % NCH;
         if (!found && mask[chan]) begin
            nxt   = SELW'(chan);
            found = 1'b1;
         end
      end
   end

   assign any = |mask;

endmodule : rr_next_sel

// File: rtl/mux_scan_reg.sv
// N-channel, W-bit mux with registered output: manual select or round-robin scan with dwell.
// Define MUX_SCAN_PARITY_EN to add the y_par even-parity output.
module mux_scan_reg
   import mux_scan_pkg::*;
#(
   parameter int NCH   = 8,
   parameter int W     = 8,
   parameter int DWELL = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH*W-1:0]  din,
   input  logic [SELW-1:0]   sel,
   input  logic              mode,
   input  logic [NCH-1:0]    ch_en,
   input  logic              start,
   output logic [W-1:0]      y,
   output logic [SELW-1:0]   y_ch,
   output logic              y_valid,
   output logic              busy
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic              y_par
`endif
);

   localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

   scan_state_e      state_q, state_d;
   logic [SELW-1:0]  ptr_q,   ptr_d;
   logic [CNTW-1:0]  cnt_q,   cnt_d;
   logic [W-1:0]     y_q,     y_d;
   logic [SELW-1:0]  yCh_q,   yCh_d;
   logic             yValid_q, yValid_d;

   logic [W-1:0]     chData [NCH];
   logic [SELW-1:0]  searchCur;
   logic [SELW-1:0]  searchNxt;
   logic             anyEn;

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      assign chData[k] = din[k*W +: W];
   end

   // In IDLE the search starts from NCH-1 so it lands on the lowest enabled channel.
   assign searchCur = (state_q == ST_SCAN) ? ptr_q : SELW'(NCH - 1);

   rr_next_sel #(
      .NCH (NCH)
   ) u_next (
      .mask (ch_en),
      .cur  (searchCur),
      .nxt  (searchNxt),
      .any  (anyEn)
   );

   // Next-state logic: exit conditions take priority over the dwell counter in SCAN.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      yCh_d    = yCh_q;
      yValid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mode == MODE_MANUAL) begin
               yCh_d = sel;
               if (int'(sel) < NCH) begin
                  y_d      = chData[sel];
                  yValid_d = 1'b1;
               end else begin
                  y_d = '0;
               end
            end else if (start && anyEn) begin
               state_d = ST_SCAN;
               ptr_d   = searchNxt;
               cnt_d   = '0;
            end
         end

         ST_SCAN: begin
            if (mode == MODE_MANUAL || !anyEn) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               y_d      = chData[ptr_q];
               yCh_d    = ptr_q;
               yValid_d = 1'b1;
               cnt_d    = '0;
               ptr_d    = searchNxt;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         y_q      <= '0;
         yCh_q    <= '0;
         yValid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         yCh_q    <= yCh_d;
         yValid_q <= yValid_d;
      end
   end

`ifdef MUX_SCAN_PARITY_EN
   logic yPar_q;

   // Parity follows y_d so it is always registered alongside the data it describes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yPar_q <= 1'b0;
      end else begin
         yPar_q <= ^y_d;
      end
   end

   assign y_par = yPar_q;
`endif

   assign y       = y_q;
   assign y_ch    = yCh_q;
   assign y_valid = yValid_q;
   assign busy    = (state_q == ST_SCAN);

endmodule : mux_scan_reg

// File: tb/tb_mux_scan_reg.sv
// Self-checking bench for mux_scan_reg: directed phases plus randomized traffic against a reference model.
// Checks y_par as well when MUX_SCAN_PARITY_EN is defined.
module tb_mux_scan_reg;

   localparam int NCH   = 8;
   localparam int W     = 8;
   localparam int DWELL = 4;
   localparam int SELW  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH*W-1:0]  din;
   logic [SELW-1:0]   sel;
   logic              mode;
   logic [NCH-1:0]    ch_en;
   logic              start;
   logic [W-1:0]      y;
   logic [SELW-1:0]   y_ch;
   logic              y_valid;
   logic              busy;
`ifdef MUX_SCAN_PARITY_EN
   logic              y_par;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model state: whether scanning, which channel is up next, cycles spent on it.
   bit           mScan;
   int           mPos;
   int           mElapsed;
   logic [W-1:0] mY;
   logic [SELW-1:0] mYCh;
   logic         mValid;

   int           strobeCh[$];
   int           strobeAt[$];

   mux_scan_reg #(
      .NCH   (NCH),
      .W     (W),
      .DWELL (DWELL)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din),
      .sel     (sel),
      .mode    (mode),
      .ch_en   (ch_en),
      .start   (start),
      .y       (y),
      .y_ch    (y_ch),
      .y_valid (y_valid),
      .busy    (busy)
`ifdef MUX_SCAN_PARITY_EN
      ,
      .y_par   (y_par)
`endif
   );

   always #5 clk = ~clk;

   function automatic int lowestEn(input logic [NCH-1:0] m);
      for (int i = 0; i < NCH; i++) begin
         if (m[i]) return i;
      end
      return 0;
   endfunction

   function automatic int nextEn(input int cur, input logic [NCH-1:0] m);
      for (int i = cur + 1; i < NCH; i++) begin
         if (m[i]) return i;
      end
      for (int i = 0; i <= cur; i++) begin
         if (m[i]) return i;
      end
      return cur;
   endfunction

   function automatic logic [W-1:0] chanOf(input logic [NCH*W-1:0] d, input int k);
      return d[k*W +: W];
   endfunction

   task automatic modelReset();
      mScan    = 1'b0;
      mPos     = 0;
      mElapsed = 0;
      mY       = '0;
      mYCh     = '0;
      mValid   = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic modelStep();
      if (!mScan) begin
         if (mode == 1'b0) begin
            mYCh = sel;
            if (int'(sel) < NCH) begin
               mY     = chanOf(din, int'(sel));
               mValid = 1'b1;
            end else begin
               mY     = '0;
               mValid = 1'b0;
            end
         end else begin
            mValid = 1'b0;
            if (start && ch_en != '0) begin
               mScan    = 1'b1;
               mPos     = lowestEn(ch_en);
               mElapsed = 0;
            end
         end
      end else begin
         mValid = 1'b0;
         if (mode == 1'b0 || ch_en == '0) begin
            mScan = 1'b0;
         end else begin
            mElapsed++;
            if (mElapsed == DWELL) begin
               mY       = chanOf(din, mPos);
               mYCh     = SELW'(mPos);
               mValid   = 1'b1;
               mElapsed = 0;
               mPos     = nextEn(mPos, ch_en);
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic m, input logic [SELW-1:0] s,
                                input logic [NCH-1:0] en, input logic st,
                                input logic [NCH*W-1:0] d);
      mode  = m;
      sel   = s;
      ch_en = en;
      start = st;
      din   = d;
   endtask

   task automatic checkOutput(input string tag);
      checks++;
      assert (y === mY) else begin
         failures++;
         $error("FAIL %s.y got=%h exp=%h", tag, y, mY);
      end
      checks++;
      assert (y_ch === mYCh) else begin
         failures++;
         $error("FAIL %s.y_ch got=%0d exp=%0d", tag, y_ch, mYCh);
      end
      checks++;
      assert (y_valid === mValid) else begin
         failures++;
         $error("FAIL %s.y_valid got=%b exp=%b", tag, y_valid, mValid);
      end
      checks++;
      assert (busy === mScan) else begin
         failures++;
         $error("FAIL %s.busy got=%b exp=%b", tag, busy, mScan);
      end
`ifdef MUX_SCAN_PARITY_EN
      checks++;
      assert (y_par === ^mY) else begin
         failures++;
         $error("FAIL %s.y_par got=%b exp=%b", tag, y_par, ^mY);
      end
`endif
   endtask

   // Clock once, then compare against the model 1 time unit after the edge.
   task automatic clockAndCheck(input string tag, input int cyc);
      modelStep();
      @(posedge clk);
      #1;
      checkOutput(tag);
      if (y_valid === 1'b1) begin
         strobeCh.push_back(int'(y_ch));
         strobeAt.push_back(cyc);
      end
   endtask

   function automatic logic [NCH*W-1:0] randDin();
      logic [NCH*W-1:0] d;
      for (int k = 0; k < NCH; k++) d[k*W +: W] = W'($urandom);
      return d;
   endfunction

   logic [NCH*W-1:0] rampDin;
   int expAll[9];
   int expSparse[8];

   initial begin
      for (int k = 0; k < NCH; k++) rampDin[k*W +: W] = 8'h10 + 8'(k);
      expAll    = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      expSparse = '{1, 4, 7, 1, 4, 2, 2, 2};

      // Reset held with random inputs and a running clock.
      rst_n = 1'b0;
      applyStimulus(1'b0, 3'd5, 8'hFF, 1'b1, randDin());
      modelReset();
      #3;
      checkOutput("reset0");
      repeat (2) begin
         @(posedge clk);
         #1;
         din = randDin();
         checkOutput("resetHold");
      end
      rst_n = 1'b1;

      // Manual sweep over a ramp pattern, also checked against literal values.
      for (int s = 0; s < NCH; s++) begin
         applyStimulus(1'b0, SELW'(s), 8'h00, 1'b0, rampDin);
         clockAndCheck("manual", 0);
         checks++;
         assert (y === 8'h10 + 8'(s)) else begin
            failures++;
            $error("FAIL manualRamp got=%h exp=%h", y, 8'h10 + 8'(s));
         end
      end

      // Random manual traffic.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, SELW'($urandom_range(0, NCH - 1)), NCH'($urandom), 1'b0, randDin());
         clockAndCheck("manualRand", 0);
      end

      // Mode=1 without start holds y and drops valid; start with empty mask is ignored.
      applyStimulus(1'b1, 3'd0, 8'h00, 1'b0, randDin());
      clockAndCheck("idleHold", 0);
      applyStimulus(1'b1, 3'd0, 8'h00, 1'b1, randDin());
      clockAndCheck("startNoMask", 0);

      // Scan with every channel enabled; a stray start mid-scan must not restart it.
      strobeCh.delete();
      strobeAt.delete();
      applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1, randDin());
      clockAndCheck("scanEntry", 0);
      for (int c = 1; c <= 36; c++) begin
         applyStimulus(1'b1, SELW'($urandom), 8'hFF, (c == 10 || c == 11), randDin());
         clockAndCheck("scanAll", c);
      end
      checks++;
      assert (strobeCh.size() == 9) else begin
         failures++;
         $error("FAIL scanAllCount got=%0d exp=9", strobeCh.size());
      end
      if (strobeCh.size() == 9) begin
         for (int i = 0; i < 9; i++) begin
            checks++;
            assert (strobeCh[i] == expAll[i]) else begin
               failures++;
               $error("FAIL scanAllSeq[%0d] got=%0d exp=%0d", i, strobeCh[i], expAll[i]);
            end
         end
         checks++;
         assert (strobeAt[0] == DWELL) else begin
            failures++;
            $error("FAIL firstStrobe got=%0d exp=%0d", strobeAt[0], DWELL);
         end
      end

      // Leave scan via mode=0, then manual tracking resumes.
      applyStimulus(1'b0, 3'd3, 8'hFF, 1'b0, rampDin);
      clockAndCheck("exitMode", 0);
      clockAndCheck("manualAfterScan", 0);

      // Sparse mask, then shrink the mask in the middle of the ch4 dwell.
      strobeCh.delete();
      strobeAt.delete();
      applyStimulus(1'b1, 3'd0, 8'b1001_0010, 1'b1, randDin());
      clockAndCheck("sparseEntry", 0);
      for (int c = 1; c <= 32; c++) begin
         applyStimulus(1'b1, 3'd0, (c <= 18) ? 8'b1001_0010 : 8'b0000_0100, 1'b0, randDin());
         clockAndCheck("sparse", c);
      end
      checks++;
      assert (strobeCh.size() == 8) else begin
         failures++;
         $error("FAIL sparseCount got=%0d exp=8", strobeCh.size());
      end
      if (strobeCh.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            assert (strobeCh[i] == expSparse[i]) else begin
               failures++;
               $error("FAIL sparseSeq[%0d] got=%0d exp=%0d", i, strobeCh[i], expSparse[i]);
            end
         end
      end

      // Empty mask during scan drops busy on the next edge with no further strobes.
      applyStimulus(1'b1, 3'd0, 8'h00, 1'b0, randDin());
      clockAndCheck("exitMask", 0);
      clockAndCheck("idleAfterMask", 0);

      // Randomized mixed traffic.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 9) != 0), SELW'($urandom),
                       ($urandom_range(0, 7) == 0) ? NCH'($urandom) : ch_en | NCH'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), randDin());
         if ($urandom_range(0, 19) == 0) ch_en = '0;
         clockAndCheck("random", 0);
      end

      // Asynchronous reset in the middle of a scan dwell.
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, randDin());
      clockAndCheck("preReset", 0);
      applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1, randDin());
      clockAndCheck("preResetEntry", 0);
      for (int c = 1; c <= 6; c++) begin
         applyStimulus(1'b1, 3'd0, 8'hFF, 1'b0, randDin());
         clockAndCheck("preResetScan", c);
      end
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("asyncReset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, 3'd6, 8'h00, 1'b0, rampDin);
      clockAndCheck("postReset", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mux_scan_reg
